// File: rtl/router_out_fifo.sv
// Per-destination output buffer of the 1x3 router: 9-bit entries (header flag + byte)
// with read-side packet length tracking so the destination can see where a packet ends.
module router_out_fifo #(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned ADDR_W = 4
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       soft_reset,
   input  logic       write_enb,
   input  logic       read_enb,
   input  logic       lfd_state,
   input  logic [7:0] data_in,
   output logic       full,
   output logic       empty,
   output logic [7:0] data_out,
   output logic       pkt_active
);

   localparam logic [ADDR_W:0] DEPTH_P = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W + 1)'(1);

   logic [8:0]      mem [DEPTH];
   logic [ADDR_W:0] wr_ptr;
   logic [ADDR_W:0] rd_ptr;
   logic [6:0]      count;
   logic [8:0]      rd_entry;
   logic            flush;
   logic            do_wr;
   logic            do_rd;

   assign flush      = !resetn || soft_reset;
   assign empty      = (wr_ptr == rd_ptr);
   assign full       = ((wr_ptr - rd_ptr) == DEPTH_P);
   assign do_wr      = write_enb && !full && !flush;
   assign do_rd      = read_enb && !empty;
   assign rd_entry   = mem[rd_ptr[ADDR_W-1:0]];
   assign pkt_active = (count != '0);

   // Storage is never cleared; a flush only drops the write of that cycle.
   always_ff @(posedge clock) begin
      if (do_wr)
         mem[wr_ptr[ADDR_W-1:0]] <= {lfd_state, data_in};
   end

   always_ff @(posedge clock) begin
      if (flush) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         data_out <= '0;
      end else begin
         if (do_wr)
            wr_ptr <= wr_ptr + PTR_ONE;
         if (do_rd) begin
            rd_ptr   <= rd_ptr + PTR_ONE;
            data_out <= rd_entry[7:0];
            // Header reload covers payload bytes plus the trailing parity byte.
            if (rd_entry[8])
               count <= {1'b0, rd_entry[7:2]} + 7'd1;
            else if (count != '0)
               count <= count - 7'd1;
         end else if (count == '0) begin
            data_out <= '0;
         end
      end
   end

endmodule
